// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: shared state encoding and field widths for the I2C master arbiter
package i2c_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANTED = 2'd1, BUSY = 2'd2, RELEASE = 2'd3} arb_state_t;
  localparam int BYTES_W = 6;
  localparam int SADDR_W = 7;
  localparam int REG_W = 8;
  localparam int DATA_W = 8;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin priority picker, first set request after the last winner
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         found,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot
);
  always_comb begin
    found = |req;
    idx = last;
    // walk farthest-first so the nearest set request after last overwrites
    for (int k = N; k >= 1; k--)
      if (req[(int'(last) + k) % N]) idx = W'((int'(last) + k) % N);
    onehot = found ? {{(N-1){1'b0}}, 1'b1} << idx : '0;
  end
endmodule

// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter: round-robin sharing of one I2C master between requesters,
// with stalled-grant timeout and a forced STOP when an owner abandons a transfer
module i2c_master_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_go,
  input  logic [NUM_REQ-1:0]         req_stop,
  input  logic [NUM_REQ-1:0]         req_rw,
  input  logic [BYTES_W*NUM_REQ-1:0] req_num_bytes,
  input  logic [SADDR_W*NUM_REQ-1:0] req_slave_addr,
  input  logic [REG_W*NUM_REQ-1:0]   req_reg_addr,
  input  logic [DATA_W*NUM_REQ-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [IDX_W-1:0]           gnt_idx,
  output logic [NUM_REQ-1:0]         req_done,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [DATA_W-1:0]          rdata,
  output logic                       timeout_err,
  output logic                       m_go,
  output logic                       m_stop,
  output logic                       m_rw,
  output logic [BYTES_W-1:0]         m_num_bytes,
  output logic [SADDR_W-1:0]         m_slave_addr,
  output logic [REG_W-1:0]           m_reg_addr,
  output logic [DATA_W-1:0]          m_wdata,
  input  logic                       m_done,
  input  logic                       m_ready,
  input  logic                       m_ack,
  input  logic [DATA_W-1:0]          m_rdata
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  arb_state_t state;
  logic [CNT_W-1:0] cnt;
  logic force_stop;
  logic found;
  logic [IDX_W-1:0] pick_idx;
  logic [NUM_REQ-1:0] pick_oh;
  logic active;
  logic own_req;
  rr_pick #(.N(NUM_REQ), .W(IDX_W)) u_pick (
    .req(req),
    .last(gnt_idx),
    .found(found),
    .idx(pick_idx),
    .onehot(pick_oh)
  );
  assign active = |gnt;
  assign own_req = req[gnt_idx];
  assign m_go = req_go[gnt_idx] & own_req & (state == GRANTED || state == BUSY);
  assign m_stop = (req_stop[gnt_idx] & active) | force_stop;
  assign m_rw = active & req_rw[gnt_idx];
  assign m_num_bytes = active ? req_num_bytes[gnt_idx*BYTES_W +: BYTES_W] : '0;
  assign m_slave_addr = active ? req_slave_addr[gnt_idx*SADDR_W +: SADDR_W] : '0;
  assign m_reg_addr = active ? req_reg_addr[gnt_idx*REG_W +: REG_W] : '0;
  assign m_wdata = active ? req_wdata[gnt_idx*DATA_W +: DATA_W] : '0;
  assign req_done = {NUM_REQ{m_done}} & gnt;
  assign req_ready = {NUM_REQ{m_ready}} & gnt;
  assign req_ack = {NUM_REQ{m_ack}} & gnt;
  assign rdata = m_rdata;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      gnt <= '0;
      gnt_idx <= IDX_W'(NUM_REQ - 1);
      cnt <= '0;
      timeout_err <= 1'b0;
      force_stop <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      force_stop <= 1'b0;
      case (state)
        IDLE: if (found && m_done) begin
          gnt <= pick_oh;
          gnt_idx <= pick_idx;
          cnt <= '0;
          state <= GRANTED;
        end
        GRANTED: begin
          cnt <= cnt + 1'b1;
          // a dropped request beats a same-cycle go, which m_go already masks
          if (!own_req) begin
            gnt <= '0;
            state <= IDLE;
          end else if (m_go) state <= BUSY;
          else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            gnt <= '0;
            timeout_err <= 1'b1;
            state <= IDLE;
          end
        end
        BUSY: if (!own_req) begin
          gnt <= '0;
          state <= m_done ? IDLE : RELEASE;
          force_stop <= !m_done;
        end
        RELEASE: if (m_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
